// File: rtl/bgr_startup_ctrl.sv
// bgr_startup_ctrl
// Power-up sequencer for the bandgap reference core. It pulses the start-up
// device, waits for the core to settle, debounces the window comparator and
// either qualifies the reference, re-kicks the core, or declares a fault.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   en         high requests the reference; low shuts the sequencer down
//   vbg_ok     asynchronous window-comparator flag from the analog macro
//   porst      start-up kick to the core (high pulls the mirror node low)
//   bgr_ready  reference qualified and stable
//   fault      sticky fault: all retries exhausted (cleared by en=0)
//   retry_cnt  re-kicks taken in the current attempt sequence (saturating)
//   state      debug state: IDLE=0 KICK=1 SETTLE=2 CHECK=3 READY=4 FAULT=5
module bgr_startup_ctrl #(
  parameter int unsigned PORST_CYCLES   = 8,
  parameter int unsigned SETTLE_CYCLES  = 64,
  parameter int unsigned GOOD_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vbg_ok,
  output logic       porst,
  output logic       bgr_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int unsigned RETRY_W = 2;

  localparam logic [CNT_W-1:0]   PORST_LD   = CNT_W'(PORST_CYCLES);
  localparam logic [CNT_W-1:0]   SETTLE_LD  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]   GOOD_LD    = CNT_W'(GOOD_CYCLES);
  localparam logic [CNT_W-1:0]   TIMEOUT_LD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KICK   = 3'd1,
    SETTLE = 3'd2,
    CHECK  = 3'd3,
    READY  = 3'd4,
    FAULT  = 3'd5
  } state_t;

  state_t state_q, state_nx;

  // cnt_q: down counter in KICK/SETTLE, timeout up counter in CHECK.
  // good_q: consecutive-high count in CHECK, consecutive-low count in READY.
  logic [CNT_W-1:0]   cnt_q, cnt_d, good_d, good_q;
  logic [CNT_W-1:0]   cnt_dec, cnt_inc, good_nx, loss_nx;
  logic [RETRY_W-1:0] retry_d, retry_inc;
  logic               porst_d, ready_d, fault_d;
  logic               retry_left;
  logic               vbg_meta, ok_s;

  // Two-flop synchronizer for the asynchronous comparator flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vbg_meta <= 1'b0;
      ok_s     <= 1'b0;
    end else begin
      vbg_meta <= vbg_ok;
      ok_s     <= vbg_meta;
    end
  end

  // Saturating counter arithmetic; counters never wrap.
  assign cnt_dec   = (cnt_q == '0) ? cnt_q : cnt_q - CNT_ONE;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign good_nx   = ok_s ? ((good_q == '1) ? good_q : good_q + CNT_ONE) : '0;
  assign loss_nx   = ok_s ? '0 : ((good_q == '1) ? good_q : good_q + CNT_ONE);
  assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + RETRY_ONE;
  assign retry_left = (32'(retry_cnt) < MAX_RETRIES);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nx;
  end

  assign state = state_q;

  // Next-state logic; en=0 overrides everything, good beats timeout in CHECK.
  always_comb begin
    state_nx = state_q;
    if (!en) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_nx = KICK;
        KICK:   if (cnt_q <= CNT_ONE) state_nx = SETTLE;
        SETTLE: if (cnt_q <= CNT_ONE) state_nx = CHECK;
        CHECK: begin
          if (good_nx == GOOD_LD)         state_nx = READY;
          else if (cnt_inc == TIMEOUT_LD) state_nx = retry_left ? KICK : FAULT;
        end
        READY:  if (loss_nx == GOOD_LD) state_nx = KICK;
        FAULT:  state_nx = FAULT;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output and counter next values, decoded from the upcoming state so the
  // registered outputs line up with the state register.
  always_comb begin
    cnt_d   = cnt_q;
    good_d  = good_q;
    retry_d = retry_cnt;
    porst_d = (state_nx == KICK);
    ready_d = (state_nx == READY);
    fault_d = (state_nx == FAULT);

    if (state_nx != state_q) begin
      // Counters reload on every state entry.
      cnt_d  = '0;
      good_d = '0;
      case (state_nx)
        KICK:    cnt_d = PORST_LD;
        SETTLE:  cnt_d = SETTLE_LD;
        default: ;
      endcase
    end else begin
      case (state_q)
        KICK, SETTLE: cnt_d = cnt_dec;
        CHECK: begin
          cnt_d  = cnt_inc;
          good_d = good_nx;
        end
        READY:   good_d = loss_nx;
        default: ;
      endcase
    end

    // Losing lock in READY starts a fresh attempt sequence.
    if (state_nx == IDLE)                             retry_d = '0;
    else if (state_q == CHECK && state_nx == KICK)    retry_d = retry_inc;
    else if (state_q == READY && state_nx == KICK)    retry_d = '0;
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      good_q    <= '0;
      retry_cnt <= '0;
      porst     <= 1'b0;
      bgr_ready <= 1'b0;
      fault     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      good_q    <= good_d;
      retry_cnt <= retry_d;
      porst     <= porst_d;
      bgr_ready <= ready_d;
      fault     <= fault_d;
    end
  end

endmodule
